// File: rtl/vga_pkg.sv
// Shared VGA-side types: the screen identifiers that the screen selector
// uses to pick which video stream reaches the display.
package vga_pkg;

    typedef enum logic [1:0] {
        START    = 2'd0,
        GAME     = 2'd1,
        PLAYER_1 = 2'd2,
        PLAYER_2 = 2'd3
    } screen_t;

endpackage

// File: rtl/screen_fsm.sv
// Game-flow controller. It decides which screen is shown: title, game, or one
// of the two win screens. Screen changes happen only on frame boundaries, so the
// selected video stream never switches partway through a frame. Every entry into
// GAME produces a one-cycle game reset pulse.
module screen_fsm #(
    parameter int WIN_HOLD_FRAMES = 300,
    parameter int LOCKOUT_FRAMES  = 30,
    parameter bit VSYNC_POL       = 1'b1,
    localparam int CW             = $clog2(WIN_HOLD_FRAMES + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             vsync,
    input  logic             btn_start,
    input  logic             p1_win,
    input  logic             p2_win,
    output vga_pkg::screen_t screen,
    output logic             game_rst,
    output logic [CW-1:0]    frame_cnt
);

    import vga_pkg::*;

    // A rematch is only reachable when the lockout ends before the hold time
    // runs out. Otherwise the lockout compare is forced off so that it never
    // uses a truncated constant.
    localparam bit          REMATCH_OK = (LOCKOUT_FRAMES < WIN_HOLD_FRAMES);
    localparam logic [CW-1:0] LOCK_CNT  = REMATCH_OK ? CW'(LOCKOUT_FRAMES) : '0;
    localparam logic [CW-1:0] HOLD_MAX  = CW'(WIN_HOLD_FRAMES);
    localparam logic [CW-1:0] HOLD_LAST = CW'(WIN_HOLD_FRAMES - 1);

    logic    vsync_q;
    logic    btn_q;
    logic    start_pend;
    logic    win_pend;
    logic    win_p2;

    logic    tick;
    logic    start_req;
    logic    lock_ok;

    screen_t       screen_d;
    logic          game_rst_d;
    logic [CW-1:0] cnt_d;
    logic          start_pend_d;
    logic          win_pend_d;
    logic          win_p2_d;

    assign tick      = VSYNC_POL ? (vsync & ~vsync_q) : (~vsync & vsync_q);
    assign start_req = btn_start & ~btn_q;
    assign lock_ok   = REMATCH_OK && (frame_cnt >= LOCK_CNT);

    // State register. The edge detectors reset to their "already seen" levels,
    // so releasing reset cannot create a fake start press or a fake frame tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            screen     <= START;
            game_rst   <= 1'b0;
            frame_cnt  <= '0;
            start_pend <= 1'b0;
            win_pend   <= 1'b0;
            win_p2     <= 1'b0;
            vsync_q    <= VSYNC_POL;
            btn_q      <= 1'b1;
        end else begin
            screen     <= screen_d;
            game_rst   <= game_rst_d;
            frame_cnt  <= cnt_d;
            start_pend <= start_pend_d;
            win_pend   <= win_pend_d;
            win_p2     <= win_p2_d;
            vsync_q    <= vsync;
            btn_q      <= btn_start;
        end
    end

    // Next-state logic. Requests are latched as they arrive and acted on at the
    // next frame tick. A request that arrives in the tick cycle itself counts.
    always_comb begin
        screen_d     = screen;
        game_rst_d   = 1'b0;
        cnt_d        = frame_cnt;
        start_pend_d = start_pend;
        win_pend_d   = win_pend;
        win_p2_d     = win_p2;

        case (screen)
            START: begin
                cnt_d      = '0;
                win_pend_d = 1'b0;
                if (start_req) begin
                    start_pend_d = 1'b1;
                end
                if (tick && start_pend_d) begin
                    screen_d     = GAME;
                    game_rst_d   = 1'b1;
                    start_pend_d = 1'b0;
                end
            end

            GAME: begin
                cnt_d        = '0;
                start_pend_d = 1'b0;
                if (!win_pend && (p1_win || p2_win)) begin
                    win_pend_d = 1'b1;
                    win_p2_d   = ~p1_win;
                end
                if (tick && win_pend_d) begin
                    screen_d   = win_p2_d ? PLAYER_2 : PLAYER_1;
                    win_pend_d = 1'b0;
                end
            end

            PLAYER_1, PLAYER_2: begin
                win_pend_d = 1'b0;
                if (start_req && lock_ok) begin
                    start_pend_d = 1'b1;
                end
                if (tick) begin
                    if (start_pend_d && lock_ok) begin
                        screen_d     = GAME;
                        game_rst_d   = 1'b1;
                        cnt_d        = '0;
                        start_pend_d = 1'b0;
                    end else if (frame_cnt == HOLD_LAST) begin
                        screen_d     = START;
                        cnt_d        = '0;
                        start_pend_d = 1'b0;
                    end else if (frame_cnt != HOLD_MAX) begin
                        cnt_d = frame_cnt + CW'(1);
                    end
                end
            end

            default: begin
                screen_d     = START;
                cnt_d        = '0;
                start_pend_d = 1'b0;
                win_pend_d   = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/screen_fsm.md
Name: screen_fsm

Overview:
- Game-flow controller. Produces the `screen` state (START, GAME, PLAYER_1, PLAYER_2 from vga_pkg) that selects which VGA stream the screen selector forwards.
- Takes a start button and win pulses from game logic.
- Changes screen only on VGA frame boundaries, so the displayed stream never switches mid-frame.
- Issues a one-cycle game reset pulse on every entry to GAME.

Parameters:
WIN_HOLD_FRAMES, 300, frames a win screen is shown before automatic return to START (5 s at 60 Hz)
LOCKOUT_FRAMES, 30, frames after entering a win screen during which start presses are discarded
VSYNC_POL, 1, active level of vsync; 1 means a frame boundary is the vsync rising edge, 0 means the falling edge

Ports:
clk  input  1  pixel clock, shared with the VGA timing chain
rst_n  input  1  asynchronous, active-low reset
vsync  input  1  vsync from the vga_tim timing stream
btn_start  input  1  debounced start button, level
p1_win  input  1  player 1 win, one-cycle pulse from game logic
p2_win  input  1  player 2 win, one-cycle pulse from game logic
screen  output  state  current screen, registered
game_rst  output  1  one-cycle pulse on entry to GAME, registered
frame_cnt  output  $clog2(WIN_HOLD_FRAMES+1)  frames elapsed in current win screen, registered

Behaviour:
- Reset (async assert, sync release):
  - screen=START, game_rst=0, frame_cnt=0.
  - Pending flags cleared.
  - Edge-detect register for btn_start resets to 1, so a button held through reset release produces no request.
  - Edge-detect register for vsync resets to the active level, so no tick is produced at reset release.
- Frame tick: single-cycle strobe, combinational from vsync and its registered copy, when vsync moves to the active level.
- Start request: btn_start rising edge (btn_start & ~btn_q).
  - Sets sticky flag start_pend.
  - A request is also valid in the cycle it occurs.
- Win request:
  - First p1_win/p2_win seen in GAME sets sticky win_pend with winner id.
  - Later pulses are ignored until the flag clears.
  - p1_win and p2_win in the same cycle: PLAYER_1 wins.
- All transitions happen on the clk edge following a frame tick cycle. Latency from the tick cycle to the screen change is 1 clk. An event in the tick cycle itself is included.
- START:
  - Tick with start pending -> GAME.
  - game_rst=1 for exactly the cycle screen first reads GAME.
  - start_pend cleared.
  - Win pulses in START are discarded.
- GAME:
  - Tick with win_pend -> PLAYER_1 or PLAYER_2 per winner id.
  - frame_cnt=0, win_pend cleared.
  - Start presses in GAME are discarded; start_pend is held at 0.
- PLAYER_1 / PLAYER_2:
  - frame_cnt increments by 1 on each tick and saturates at WIN_HOLD_FRAMES.
  - Start presses while frame_cnt < LOCKOUT_FRAMES are discarded.
  - Tick with start pending and frame_cnt >= LOCKOUT_FRAMES -> GAME (rematch), with game_rst pulse.
  - Otherwise, tick with frame_cnt == WIN_HOLD_FRAMES-1 -> START, frame_cnt=0.
  - When both conditions hold, the rematch takes precedence.
  - Win pulses are discarded.
- frame_cnt is 0 in START and GAME.
- Illegal screen encoding -> START on next clk, with no game_rst.
- rst_n asserted mid-frame or mid-count: immediate return to reset values. No game_rst pulse is emitted by reset.
- If LOCKOUT_FRAMES >= WIN_HOLD_FRAMES, rematch is impossible; only the timeout path exits a win screen.

Test Plan:
- Reset with btn_start held high, release rst_n, toggle vsync for 3 frames -> screen stays START, game_rst never 1.
- In START, btn_start 0->1 mid-frame -> screen=GAME exactly 1 clk after the next vsync tick; game_rst high that same single cycle.
- In GAME, p1_win and p2_win pulsed in the same cycle, then p2_win alone 10 cycles later -> screen=PLAYER_1 after next tick; frame_cnt=0.
- In PLAYER_2, WIN_HOLD_FRAMES=8, LOCKOUT_FRAMES=3, no button -> frame_cnt steps 1..7 per tick; screen=START on the 8th tick.
- In PLAYER_1, LOCKOUT_FRAMES=3:
  - Press at frame_cnt=1 -> ignored.
  - Press at frame_cnt=4 -> GAME with game_rst pulse on next tick.
- Assert rst_n low while in GAME with win_pend set -> screen=START and frame_cnt=0 asynchronously; after release, the old win is not replayed.
